// File: rtl/fifo_rd_packer.sv
// Read-side drain stage for the async FIFO. Pops DSIZE-bit entries, packs
// PACK of them (lane 0 oldest) into one OSIZE-bit word and offers it on a
// valid/ready output. A flush pulse pushes out a partially filled word
// together with its lane count so no entries are stranded.
module fifo_rd_packer #(
  parameter  int DSIZE = 6,
  parameter  int PACK  = 4,
  localparam int OSIZE = DSIZE * PACK,
  localparam int CW    = $clog2(PACK) + 1
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             flush,
  output logic [OSIZE-1:0] out_data,
  output logic [CW-1:0]    out_cnt,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int            LW        = $clog2(PACK);
  localparam logic [CW-1:0] FILL_FULL = CW'(PACK);
  localparam logic [CW-1:0] FILL_LAST = CW'(PACK - 1);

  // Mask selecting the lowest cnt lanes; used to zero stale upper lanes
  // when a partial word is emitted.
  function automatic logic [OSIZE-1:0] lane_mask(input logic [CW-1:0] cnt);
    logic [OSIZE-1:0] m;
    m = '0;
    for (int i = 0; i < PACK; i++) begin
      if (CW'(i) < cnt) m[i*DSIZE +: DSIZE] = '1;
    end
    return m;
  endfunction

  // Full word formed from the newest entry on the top lane and the
  // accumulated lanes 0..PACK-2 below it.
  function automatic logic [OSIZE-1:0] pack_last(input logic [OSIZE-1:0] a,
                                                 input logic [DSIZE-1:0] d);
    return {d, a[OSIZE-DSIZE-1:0]};
  endfunction

  // Accumulator state: acc/fill hold captured lanes, vld_p1 marks an entry
  // popped last cycle whose data is on rdata now.
  logic [OSIZE-1:0] acc;
  logic [CW-1:0]    fill;
  logic             vld_p1;
  logic             flushing;

  logic             slot_free;
  logic [CW-1:0]    fill_pend;
  logic             rinc_c;
  logic             cap_last;
  logic             cap_emit;
  logic             flush_req;
  logic             flush_act;
  logic             drain_ok;
  logic             acc_emit;
  logic             flush_done;
  logic [LW-1:0]    cap_lane;

  // Pop request and emission decisions, all from registered state and the
  // current handshake/empty inputs.
  always_comb begin
    slot_free = !out_valid || out_ready;
    fill_pend = fill + CW'(vld_p1);
    rinc_c    = !rrst && !rempty && !flushing &&
                ((fill_pend < FILL_FULL) ||
                 (vld_p1 && (fill == FILL_LAST) && slot_free));
    // The in-flight entry completes the word this cycle.
    cap_last  = vld_p1 && (fill == FILL_LAST);
    cap_emit  = cap_last && slot_free;
    // A flush takes effect in its own cycle; a second one while flushing
    // is dropped.
    flush_req = flush && !flushing;
    flush_act = flushing || flush_req;
    // Nothing still on its way from the FIFO: the accumulator is final.
    drain_ok  = flush_act && !vld_p1 && !rinc_c;
    // Emit straight from acc: a full word held for backpressure, or a
    // flushed partial word.
    acc_emit  = slot_free && !vld_p1 &&
                ((fill == FILL_FULL) || (drain_ok && (fill != '0)));
    flush_done = drain_ok && ((fill == '0) || slot_free);
    cap_lane  = fill[LW-1:0];
  end

  assign rinc = rinc_c;

  // p0 -> p1: pop issued this cycle, data expected next cycle.
  // p1 -> acc: capture rdata into the next free lane.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      acc      <= '0;
      fill     <= '0;
      vld_p1   <= 1'b0;
      flushing <= 1'b0;
    end else begin
      vld_p1 <= rinc_c;
      if (vld_p1) acc[int'(cap_lane)*DSIZE +: DSIZE] <= rdata;
      if (acc_emit || cap_emit) begin
        fill <= '0;
      end else if (vld_p1) begin
        fill <= fill + CW'(1);
      end
      if (flush_done) begin
        flushing <= 1'b0;
      end else if (flush_req) begin
        flushing <= 1'b1;
      end
    end
  end

  // acc -> output register: load a finished word, otherwise hold until
  // accepted.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      out_data  <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (cap_emit) begin
      out_data  <= pack_last(acc, rdata);
      out_cnt   <= FILL_FULL;
      out_valid <= 1'b1;
    end else if (acc_emit) begin
      out_data  <= acc & lane_mask(fill);
      out_cnt   <= fill;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
